// File: rtl/lc3_mem_access_ctrl.sv
// LC-3 memory-class instruction sequencer (LD/LDI/LDR/ST/STI/STR/LEA).
// Steers the external address adder, captures the effective address, runs
// single or indirect memory transactions over req/ready, and reports the
// load data or LEA address with a one-cycle done pulse.
module lc3_mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic [15:0] st_data,
  input  logic [15:0] addr_in,
  output logic        addr1_mux,
  output logic [1:0]  addr2_mux,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        err
);

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] SEL2_ZERO  = 2'b00;
  localparam logic [1:0] SEL2_OFF6  = 2'b01;
  localparam logic [1:0] SEL2_OFF9  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD,
    S_IND,
    S_WR,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [15:0]      data_q, data_d;
  logic [15:0]      mar_q, mar_d;
  logic [15:0]      result_q, result_d;
  logic             err_q, err_d;
  logic             ind_q, ind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             addr1_d;
  logic [1:0]       addr2_d;
  logic             req_d, we_d, busy_d, done_d;

  logic             timeout_hit;
  logic             is_indirect;

  // Offset fields of the IR are consumed only by the external adder.
  logic unused_ir;
  assign unused_ir = ^ir[11:0];

  assign timeout_hit = (cnt_q == CNT_LAST) && !mem_ready;
  assign is_indirect = (op_q == OP_LDI) || (op_q == OP_STI);

  assign mem_addr  = mar_q;
  assign mem_wdata = data_q;
  assign result    = result_q;
  assign err       = err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ADDR;
      S_ADDR: begin
        case (op_q)
          OP_LEA:                         state_d = S_DONE;
          OP_LD, OP_LDR, OP_LDI, OP_STI:  state_d = S_RD;
          OP_ST, OP_STR:                  state_d = S_WR;
          default:                        state_d = S_DONE;
        endcase
      end
      S_RD: begin
        if (mem_ready) state_d = (is_indirect && !ind_q) ? S_IND : S_DONE;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_IND:  state_d = (op_q == OP_LDI) ? S_RD : S_WR;
      S_WR: begin
        if (mem_ready || timeout_hit) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for datapath registers and registered outputs.
  always_comb begin
    op_d     = op_q;
    data_d   = data_q;
    mar_d    = mar_q;
    result_d = result_q;
    err_d    = err_q;
    ind_d    = ind_q;
    cnt_d    = '0;
    addr1_d  = 1'b0;
    addr2_d  = SEL2_ZERO;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = ir[15:12];
          data_d = st_data;
          err_d  = 1'b0;
          ind_d  = 1'b0;
        end
      end
      S_ADDR: begin
        mar_d = addr_in;
        case (op_q)
          OP_LEA: result_d = addr_in;
          OP_LD, OP_LDR, OP_LDI, OP_STI, OP_ST, OP_STR: ;
          default: err_d = 1'b1;
        endcase
      end
      S_RD: begin
        if (mem_ready) begin
          if (is_indirect && !ind_q) begin
            mar_d = mem_rdata;
            ind_d = 1'b1;
          end else begin
            result_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      S_WR: begin
        if (timeout_hit) err_d = 1'b1;
      end
      default: ;
    endcase

    // Counter restarts on each entry to RD/WR and counts cycles spent waiting.
    if ((state_d == state_q) && ((state_q == S_RD) || (state_q == S_WR)))
      cnt_d = cnt_q + CNT_W'(1);

    // Adder selects are only meaningful while the effective address is formed.
    if (state_d == S_ADDR) begin
      case (ir[15:12])
        OP_LD, OP_LDI, OP_ST, OP_STI, OP_LEA: begin
          addr1_d = 1'b0;
          addr2_d = SEL2_OFF9;
        end
        OP_LDR, OP_STR: begin
          addr1_d = 1'b1;
          addr2_d = SEL2_OFF6;
        end
        default: ;
      endcase
    end

    req_d  = (state_d == S_RD) || (state_d == S_WR);
    we_d   = (state_d == S_WR);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      data_q    <= '0;
      mar_q     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      ind_q     <= 1'b0;
      cnt_q     <= '0;
      addr1_mux <= 1'b0;
      addr2_mux <= SEL2_ZERO;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      op_q      <= op_d;
      data_q    <= data_d;
      mar_q     <= mar_d;
      result_q  <= result_d;
      err_q     <= err_d;
      ind_q     <= ind_d;
      cnt_q     <= cnt_d;
      addr1_mux <= addr1_d;
      addr2_mux <= addr2_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Randomized bench for lc3_mem_access_ctrl with a transaction-level model.
module tb_lc3_mem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ir, st_data, addr_in;
  logic        addr1_mux;
  logic [1:0]  addr2_mux;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy, done, err;
  logic [15:0] result;

  logic [15:0] mem [0:65535];
  logic [15:0] model_res;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3_mem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .st_data(st_data),
    .addr_in(addr_in), .addr1_mux(addr1_mux), .addr2_mux(addr2_mux),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sext6(input logic [15:0] v);
    return {{10{v[5]}}, v[5:0]};
  endfunction
  function automatic logic [15:0] sext9(input logic [15:0] v);
    return {{7{v[8]}}, v[8:0]};
  endfunction
  function automatic logic [15:0] sext11(input logic [15:0] v);
    return {{5{v[10]}}, v[10:0]};
  endfunction

  // External address adder as seen by the block.
  function automatic logic [15:0] adder(input logic a1, input logic [1:0] a2,
                                        input logic [15:0] pc, input logic [15:0] sr1,
                                        input logic [15:0] irv);
    logic [15:0] off;
    case (a2)
      2'b00:   off = 16'h0000;
      2'b01:   off = sext6(irv);
      2'b10:   off = sext9(irv);
      default: off = sext11(irv);
    endcase
    return (a1 ? sr1 : pc) + off;
  endfunction

  // One instruction: predict accesses, latency and result, then drive and observe.
  task automatic run_txn(input logic [15:0] ir_v, input logic [15:0] sd,
                         input logic [15:0] pc, input logic [15:0] sr1,
                         input int w0, input int w1);
    logic [3:0]  op;
    logic [15:0] ea, exp_res;
    logic        exp_err, exp_a1;
    logic [1:0]  exp_a2;
    logic [15:0] paddr [2];
    logic        pwe [2];
    int          pw [2];
    int          nplan, nexp, cyc, exp_lat, exp_reqc;
    int          got_lat, nseen, reqcnt, reqc_total;
    logic        prev_req;

    op = ir_v[15:12];
    pw[0] = w0; pw[1] = w1;
    nplan = 0; exp_err = 1'b0; exp_res = model_res;
    exp_a1 = 1'b0; exp_a2 = 2'b00;
    paddr[0] = '0; paddr[1] = '0; pwe[0] = 1'b0; pwe[1] = 1'b0;
    if (op == 4'b0110 || op == 4'b0111) begin
      ea = sr1 + sext6(ir_v); exp_a1 = 1'b1; exp_a2 = 2'b01;
    end else begin
      ea = pc + sext9(ir_v);
      if (op inside {4'b0010, 4'b1010, 4'b0011, 4'b1011, 4'b1110}) exp_a2 = 2'b10;
    end
    case (op)
      4'b1110:          exp_res = ea;
      4'b0010, 4'b0110: begin nplan = 1; paddr[0] = ea; end
      4'b0011, 4'b0111: begin nplan = 1; paddr[0] = ea; pwe[0] = 1'b1; end
      4'b1010:          begin nplan = 2; paddr[0] = ea; paddr[1] = mem[ea]; end
      4'b1011:          begin nplan = 2; paddr[0] = ea; paddr[1] = mem[ea]; pwe[1] = 1'b1; end
      default:          exp_err = 1'b1;
    endcase

    cyc = 1; nexp = 0; exp_reqc = 0;
    for (int k = 0; k < nplan; k++) begin
      nexp++;
      if (pw[k] >= T) begin
        cyc += T; exp_reqc += T; exp_err = 1'b1;
        break;
      end
      cyc += pw[k] + 1; exp_reqc += pw[k] + 1;
      if (k < nplan - 1) cyc += 1;
    end
    exp_lat = cyc + 1;
    if (!exp_err) begin
      if (op == 4'b0010 || op == 4'b0110) exp_res = mem[ea];
      if (op == 4'b1010) exp_res = mem[mem[ea]];
    end

    @(negedge clk);
    start = 1'b1; ir = ir_v; st_data = sd; mem_ready = 1'b0;
    got_lat = -1; nseen = 0; reqcnt = 0; reqc_total = 0; prev_req = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      ir = 16'($urandom); st_data = 16'($urandom);
      if (c == 1) begin
        check("addr1_sel", 32'(addr1_mux), 32'(exp_a1));
        check("addr2_sel", 32'(addr2_mux), 32'(exp_a2));
      end
      if (c == 2) check("sel_idle", 32'({addr1_mux, addr2_mux}), 32'd0);
      addr_in = adder(addr1_mux, addr2_mux, pc, sr1, ir_v);
      if (mem_req) begin
        if (!prev_req) begin nseen++; reqcnt = 0; end
        reqc_total++;
        if (nseen <= 2 && nseen >= 1) begin
          check("acc_addr", 32'(mem_addr), 32'(paddr[nseen-1]));
          check("acc_we", 32'(mem_we), 32'(pwe[nseen-1]));
          if (pwe[nseen-1]) check("acc_wdata", 32'(mem_wdata), 32'(sd));
        end
        reqcnt++;
        if (nseen >= 1 && nseen <= 2 && reqcnt == pw[nseen-1] + 1) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
      end
      prev_req = mem_req;
      if (done) begin got_lat = c; break; end
      check("busy_run", 32'(busy), 32'd1);
    end
    check("latency", 32'(got_lat), 32'(exp_lat));
    check("err", 32'(err), 32'(exp_err));
    check("result", 32'(result), 32'(exp_res));
    check("busy_done", 32'(busy), 32'd1);
    check("n_access", 32'(nseen), 32'(nexp));
    check("req_cycles", 32'(reqc_total), 32'(exp_reqc));
    @(negedge clk);
    mem_ready = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("req_idle", 32'(mem_req), 32'd0);
    model_res = exp_res;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    rst = 1'b1; start = 1'b0; ir = '0; st_data = '0; addr_in = '0;
    mem_rdata = '0; mem_ready = 1'b0; model_res = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'({addr1_mux, addr2_mux, mem_req, mem_we, busy, done, err}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    mem[16'h3006] = 16'hBEEF;
    run_txn(16'h2405, 16'h0000, 16'h3001, 16'h0000, 0, 0);
    mem[16'h4000] = 16'h5000;
    mem[16'h5000] = 16'h1234;
    run_txn(16'hA002, 16'h0000, 16'h3FFE, 16'h0000, 0, 0);
    run_txn(16'h7283, 16'hCAFE, 16'h1111, 16'h2100, 3, 0);
    check("str_mem", 32'(mem[16'h2103]), 32'h0000CAFE);
    run_txn(16'hE1FF, 16'h0000, 16'h3000, 16'h0000, 0, 0);
    run_txn(16'h8000, 16'h0000, 16'h3000, 16'h0000, 0, 0);
    run_txn(16'h2405, 16'h0000, 16'h3001, 16'h0000, T, 0);
    run_txn(16'h2405, 16'h0000, 16'h3001, 16'h0000, T - 1, 0);
    run_txn(16'hB002, 16'h7777, 16'h3FFE, 16'h0000, 1, T);

    // Reset while a read is outstanding.
    @(negedge clk);
    start = 1'b1; ir = 16'h2405; st_data = '0;
    @(negedge clk);
    start = 1'b0;
    addr_in = 16'h3006;
    for (int c = 0; c < 5 && !mem_req; c++) @(negedge clk);
    check("rd_reached", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_res = '0;
    check("rst_res2", 32'(result), 32'd0);
    mem[16'h3006] = 16'hBEEF;
    run_txn(16'h2405, 16'h0000, 16'h3001, 16'h0000, 0, 0);

    for (int n = 0; n < 300; n++) begin
      run_txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
